// File: rtl/audio_pwm_out.sv
`default_nettype none
// ============================================================================
//  Module      : audio_pwm_out
//  Description : Sample-rate strobe generator, volume/mute scaling and
//                double-buffered 8-bit PWM audio output stage.
//  Revision    : 1.0 - initial release
// ============================================================================
module audio_pwm_out #(
    parameter int CLK_HZ    = 10_000_000,
    parameter int SAMPLE_HZ = 8_000
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       play,
    input  logic       mute,
    input  logic [2:0] vol,
    input  logic [7:0] sample,
    output logic       sample_en,
    output logic [7:0] duty,
    output logic       pwm_out
);

    localparam int c_div   = CLK_HZ / SAMPLE_HZ;
    localparam int c_div_w = $clog2(c_div);
    localparam logic [c_div_w-1:0] c_div_last = c_div_w'(c_div - 1);
    localparam logic [c_div_w-1:0] c_div_pre  = c_div_w'(c_div - 2);
    localparam logic [c_div_w-1:0] c_div_one  = c_div_w'(1);
    localparam logic [7:0]         c_mid      = 8'd128;

    logic [c_div_w-1:0] r_div_cnt;
    logic               r_sample_en;
    logic               r_cap_pend;
    logic [7:0]         r_pending;
    logic [7:0]         r_duty;
    logic [7:0]         r_pwm_cnt;
    logic               r_pwm_out;

    logic signed [8:0]  w_s;
    logic [3:0]         w_gain;
    logic signed [11:0] w_prod;
    logic signed [11:0] w_scaled;
    logic [7:0]         w_level;
    logic               w_unused;

    // Offset-binary to signed, scale by (vol+1)/8 with floor; result fits 8 bits.
    assign w_s      = $signed({1'b0, sample}) - 9'sd128;
    assign w_gain   = {1'b0, vol} + 4'd1;
    assign w_prod   = $signed({{3{w_s[8]}}, w_s}) * $signed({8'd0, w_gain});
    assign w_scaled = w_prod >>> 3;
    assign w_level  = w_scaled[7:0] + c_mid;
    assign w_unused = ^w_scaled[11:8];

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_div_cnt   <= '0;
            r_sample_en <= 1'b0;
            r_cap_pend  <= 1'b0;
            r_pending   <= c_mid;
            r_duty      <= c_mid;
            r_pwm_cnt   <= 8'd0;
            r_pwm_out   <= 1'b0;
        end else begin
            // Strobe is registered one count early so it is high while div_cnt==DIV-1.
            if (play) begin
                r_div_cnt   <= (r_div_cnt == c_div_last) ? '0 : r_div_cnt + c_div_one;
                r_sample_en <= (r_div_cnt == c_div_pre);
            end else begin
                r_div_cnt   <= '0;
                r_sample_en <= 1'b0;
            end

            r_cap_pend <= r_sample_en;

            if (!play) begin
                r_pending <= c_mid;
            end else if (r_cap_pend) begin
                r_pending <= mute ? c_mid : w_level;
            end

            r_pwm_cnt <= r_pwm_cnt + 8'd1;

            // Duty only moves at the period boundary, so a same-cycle capture lands next period.
            if (r_pwm_cnt == 8'hFF) begin
                r_duty <= r_pending;
            end

            r_pwm_out <= (r_pwm_cnt < r_duty);
        end
    end

    assign sample_en = r_sample_en;
    assign duty      = r_duty;
    assign pwm_out   = r_pwm_out;

endmodule
`default_nettype wire

// File: tb/tb_audio_pwm_out.sv
`default_nettype none
// ============================================================================
//  Module      : tb_audio_pwm_out
//  Description : Directed, table-driven self-checking bench for audio_pwm_out.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_audio_pwm_out;

    logic       clk;
    logic       nrst;
    logic       play;
    logic       mute;
    logic [2:0] vol;
    logic [7:0] sample;
    logic       sample_en;
    logic [7:0] duty;
    logic       pwm_out;

    int          total;
    int          bad;
    int unsigned cyc;

    typedef struct {
        logic [2:0] vol;
        logic       mute;
        logic [7:0] sample;
        int         exp_duty;
    } vec_t;

    vec_t vecs[12];

    audio_pwm_out #(
        .CLK_HZ    (10_000_000),
        .SAMPLE_HZ (8_000)
    ) dut (
        .clk       (clk),
        .nrst      (nrst),
        .play      (play),
        .mute      (mute),
        .vol       (vol),
        .sample    (sample),
        .sample_en (sample_en),
        .duty      (duty),
        .pwm_out   (pwm_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edges since reset release; the PWM counter should equal cyc mod 256.
    always @(posedge clk or negedge nrst) begin
        if (!nrst) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input int k);
        repeat (k) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_strobe(output int n);
        bit found;
        found = 1'b0;
        n     = -1;
        for (int i = 1; i <= 3000 && !found; i++) begin
            @(posedge clk);
            #1;
            if (sample_en) begin
                found = 1'b1;
                n     = i;
            end
        end
    endtask

    task automatic wait_phase(input int ph);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            @(posedge clk);
            #1;
            if (int'(cyc % 256) == ph) found = 1'b1;
        end
        if (!found) chk("phase_timeout", 0, 1);
    endtask

    task automatic count_high(output int hi);
        hi = 0;
        for (int i = 0; i < 256; i++) begin
            @(posedge clk);
            #1;
            if (pwm_out) hi++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int hi;
        bit found;

        vecs[0]  = '{3'd7, 1'b0, 8'hFF, 255};
        vecs[1]  = '{3'd7, 1'b0, 8'h00, 0};
        vecs[2]  = '{3'd7, 1'b0, 8'h80, 128};
        vecs[3]  = '{3'd3, 1'b0, 8'h00, 64};
        vecs[4]  = '{3'd1, 1'b0, 8'hC0, 144};
        vecs[5]  = '{3'd0, 1'b0, 8'h81, 128};
        vecs[6]  = '{3'd0, 1'b0, 8'h7F, 127};
        vecs[7]  = '{3'd7, 1'b1, 8'hFF, 128};
        vecs[8]  = '{3'd7, 1'b0, 8'hFF, 255};
        vecs[9]  = '{3'd5, 1'b0, 8'h40, 80};
        vecs[10] = '{3'd2, 1'b0, 8'hFF, 175};
        vecs[11] = '{3'd6, 1'b0, 8'h01, 16};

        total  = 0;
        bad    = 0;
        nrst   = 1'b0;
        play   = 1'b0;
        mute   = 1'b0;
        vol    = 3'd7;
        sample = 8'h80;

        // Reset state
        step(3);
        chk("rst_sample_en", int'(sample_en), 0);
        chk("rst_duty", int'(duty), 128);
        chk("rst_pwm_out", int'(pwm_out), 0);

        // Strobe timing from reset release
        play = 1'b1;
        @(negedge clk);
        nrst = 1'b1;
        wait_strobe(n);
        chk("first_strobe_cycle", n + 1, 1250);
        step(1);
        chk("strobe_width", int'(sample_en), 0);
        wait_strobe(n);
        chk("strobe_period", n + 1, 1250);

        // play=0 holds the divider and silences the output
        play = 1'b0;
        hi = 0;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            #1;
            if (sample_en) hi++;
        end
        chk("no_strobe_play0", hi, 0);
        chk("duty_play0", int'(duty), 128);
        play = 1'b1;
        wait_strobe(n);
        chk("restart_strobe_cycle", n + 1, 1250);

        // Arithmetic / volume / mute vectors
        for (int v = 0; v < 12; v++) begin
            vol    = vecs[v].vol;
            mute   = vecs[v].mute;
            sample = vecs[v].sample;
            wait_strobe(n);
            step(300);
            chk($sformatf("vec%0d_duty", v), int'(duty), vecs[v].exp_duty);
            count_high(hi);
            chk($sformatf("vec%0d_high_clks", v), hi, vecs[v].exp_duty);
        end

        // Pending changes at pwm_cnt=100; duty must wait for the wrap
        play = 1'b0;
        step(300);
        wait_phase(129);
        vol    = 3'd7;
        mute   = 1'b0;
        sample = 8'hFF;
        play   = 1'b1;
        step(1251);
        chk("db_mid_period", int'(duty), 128);
        step(155);
        chk("db_before_wrap", int'(duty), 128);
        step(1);
        chk("db_after_wrap", int'(duty), 255);

        // Capture lands on the wrap cycle: old value now, new one a period later
        play = 1'b0;
        step(300);
        wait_phase(29);
        sample = 8'h00;
        play   = 1'b1;
        step(1251);
        chk("sim_wrap_old", int'(duty), 128);
        step(255);
        chk("sim_before_next", int'(duty), 128);
        step(1);
        chk("sim_next_wrap_new", int'(duty), 0);

        // Asynchronous reset mid-period with duty=200
        sample = 8'hC8;
        wait_strobe(n);
        step(300);
        chk("pre_reset_duty", int'(duty), 200);
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            @(posedge clk);
            #1;
            if (pwm_out) found = 1'b1;
        end
        chk("pre_reset_pwm_high", int'(pwm_out), 1);
        #2;
        nrst = 1'b0;
        #1;
        chk("async_rst_duty", int'(duty), 128);
        chk("async_rst_pwm_out", int'(pwm_out), 0);
        chk("async_rst_sample_en", int'(sample_en), 0);
        @(negedge clk);
        nrst = 1'b1;
        #1;
        chk("post_rst_duty", int'(duty), 128);
        wait_strobe(n);
        chk("post_rst_first_strobe", n + 1, 1250);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/audio_pwm_out.md
Name: audio_pwm_out

Overview:
Downstream output stage for the drum sample players. It generates the 8 kHz sample-rate strobe that advances the player's address counter. It captures the player's 8-bit offset-binary sample, applies a 3-bit volume and a mute, and drives a 1-bit PWM audio pin. Duty updates are double-buffered so they change only on PWM period boundaries, which keeps the output glitch-free.

Parameters:
CLK_HZ, 10000000, system clock frequency in Hz
SAMPLE_HZ, 8000, sample strobe rate in Hz; DIV = CLK_HZ/SAMPLE_HZ (integer, ≥ 258) clocks per sample

Ports:
clk  input  1  system clock, all logic on rising edge
nrst  input  1  asynchronous active-low reset
play  input  1  1 = run divider and strobes; 0 = hold divider and output silence
mute  input  1  1 = force midscale duty
vol  input  3  volume; gain = (vol+1)/8
sample  input  8  offset-binary sample from the player, 128 = silence
sample_en  output  1  one-cycle strobe every DIV clocks; drives the player's en
duty  output  8  active duty value, exposed for verification
pwm_out  output  1  PWM audio output

Behaviour:
- Reset (nrst low, asynchronous), all registers cleared as follows:
  - div_cnt=0, sample_en=0, cap_pend=0, pending=128, duty=128, pwm_cnt=0, pwm_out=0.
- Releasing reset mid-sample discards any partial period. No strobe appears until DIV clocks after release.
- Divider (div_cnt):
  - Counts 0..DIV-1 while play=1.
  - sample_en=1 for exactly the cycle in which div_cnt==DIV-1, then div_cnt wraps to 0.
  - play=0 holds div_cnt at 0 and sample_en at 0.
  - A play 0→1 edge produces the first strobe DIV cycles later.
- Capture:
  - The player updates its address on the strobe edge, so the new sample is valid one cycle after sample_en.
  - cap_pend is sample_en delayed one cycle. When cap_pend=1, compute and register pending.
  - Capture-to-pending latency is 1 clock after cap_pend.
- Arithmetic:
  - s = {1'b0,sample} − 128, 9-bit signed, range −128..127.
  - p = s × (vol+1), 12-bit signed.
  - scaled = p >>> 3 (arithmetic shift, floor).
  - pending = scaled + 128, always in range 0..255, no saturation needed.
  - mute=1 at capture time, or play=0, forces pending=128.
- PWM:
  - pwm_cnt is a free-running 8-bit counter (0..255, wrap), running regardless of play.
  - duty loads from pending only on the cycle pwm_cnt wraps 255→0.
  - A pending change mid-period therefore takes effect at the next period start.
  - pwm_out is registered: pwm_out <= (pwm_cnt < duty).
  - duty=0 gives a constant-low output; duty=255 gives high for 255 of 256 clocks.
- Simultaneous events:
  - If cap_pend and the PWM wrap land on the same cycle, duty takes the OLD pending; the new pending is used at the following wrap.
  - play falling while cap_pend=1: cap_pend still completes, but the forced 128 wins.
- Latency and rates:
  - Worst-case sample-to-pin latency is 2 + 256 clocks.
  - DIV ≥ 258 guarantees at most one capture per PWM period plus margin.

Test Plan:
- Reset then play=1, CLK_HZ=10e6 → first sample_en at cycle 1250 after release, then every 1250 clocks, always 1 cycle wide; play=0 → no strobes and div_cnt=0.
- vol=7, mute=0: sample=0xFF → pending=255; sample=0x00 → pending=0, pwm_out constant low after the next wrap; sample=0x80 → pending=128, giving 128 high / 128 low clocks per period.
- Arithmetic: vol=3, sample=0x00 → 64; vol=1, sample=0xC0 → 144; vol=0, sample=0x81 → 128; vol=0, sample=0x7F → 127 (floor).
- Double buffer: change sample so that pending updates at pwm_cnt=100 → duty unchanged until pwm_cnt wraps to 0, then equals the new pending. Also force cap_pend on the wrap cycle → old value loaded, new value loaded one period later.
- mute=1 with sample=0xFF → pending=128. Deassert mute → the next capture returns 255.
- Assert nrst low asynchronously mid-period with duty=200 → all outputs go to reset values immediately, without waiting for a clock edge. After release → duty=128, and the first strobe comes DIV cycles later.
